// File: rtl/gastric_pkg.sv
// Shared state encoding, default timing constants and the interval floor
// for the gastric slow-wave demand pacer.
package gastric_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_PULSE    = 2'd1,
        ST_REFRACT  = 2'd2,
        ST_ESCAPE   = 2'd3
    } pacer_state_t;

    localparam int DEFAULT_INTERVAL = 400;
    localparam int REFRACTORY       = 40;
    localparam int PULSE_CYCLES     = 2;

    // Shortest escape interval that still leaves room for pulse plus refractory.
    function automatic int min_interval(input int refractory, input int pulse_cycles);
        return refractory + pulse_cycles;
    endfunction

endpackage

// File: rtl/gastric_pacer_rise_detect.sv
// Rising-edge detector for the intrinsic sense level: one-cycle strobe when
// sense is high and was low on the previous cycle.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sense,
    output logic rise
);

    logic sense_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sense_q <= 1'b0;
        end else begin
            sense_q <= sense;
        end
    end

    assign rise = sense & ~sense_q;

endmodule

// File: rtl/gastric_pacer.sv
// Demand pacer driving ring 0: paces at the escape interval unless an intrinsic
// beat is sensed. Optional sensed-beat hysteresis with GASTRIC_PACER_HYST_EN.
module gastric_pacer
    import gastric_pkg::*;
#(
    parameter int CNT_W            = 16,
    parameter int DEFAULT_INTERVAL = gastric_pkg::DEFAULT_INTERVAL,
    parameter int REFRACTORY       = gastric_pkg::REFRACTORY,
    parameter int PULSE_CYCLES     = gastric_pkg::PULSE_CYCLES
`ifdef GASTRIC_PACER_HYST_EN
    ,
    parameter int HYST_CYCLES      = 50
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             interval_wr,
    input  logic [CNT_W-1:0] interval_data,
    input  logic             sense,
    output logic             activate,
    output logic             paced,
    output logic             sensed_evt,
    output logic [15:0]      beat_count,
    output pacer_state_t     pacer_state
);

    localparam logic [CNT_W-1:0] MIN_INT   = CNT_W'(min_interval(REFRACTORY, PULSE_CYCLES));
    localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] REFR_LAST = CNT_W'(REFRACTORY - 1);

    pacer_state_t     state, state_n;
    logic [CNT_W-1:0] timer, timer_n, timer_inc;
    logic [CNT_W-1:0] interval_reg, shadow, shadow_n, sensed_shadow;
    logic             act_n, paced_n, sensed_n;
    logic [15:0]      beat_n;
    logic             rise;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .sense (sense),
        .rise  (rise)
    );

`ifdef GASTRIC_PACER_HYST_EN
    logic [CNT_W:0] hyst_sum;
    assign hyst_sum      = {1'b0, interval_reg} + (CNT_W+1)'(HYST_CYCLES);
    assign sensed_shadow = hyst_sum[CNT_W] ? '1 : hyst_sum[CNT_W-1:0];
`else
    assign sensed_shadow = interval_reg;
`endif

    assign timer_inc   = (timer == '1) ? timer : timer + 1'b1;
    assign pacer_state = state;

    always_comb begin
        state_n  = state;
        timer_n  = timer_inc;
        shadow_n = shadow;
        act_n    = 1'b0;
        paced_n  = 1'b0;
        sensed_n = 1'b0;
        if (!enable) begin
            state_n = ST_DISABLED;
            timer_n = '0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    state_n  = ST_REFRACT;
                    timer_n  = '0;
                    shadow_n = interval_reg;
                end
                ST_PULSE: begin
                    if (timer_inc < PULSE_LEN) act_n = 1'b1;
                    else                       state_n = ST_REFRACT;
                end
                ST_REFRACT: begin
                    if (timer >= REFR_LAST) state_n = ST_ESCAPE;
                end
                ST_ESCAPE: begin
                    // A sensed beat on the expiry cycle still inhibits the pace.
                    if (rise) begin
                        sensed_n = 1'b1;
                        timer_n  = '0;
                        state_n  = ST_REFRACT;
                        shadow_n = sensed_shadow;
                    end else if (timer >= shadow - 1'b1) begin
                        act_n    = 1'b1;
                        paced_n  = 1'b1;
                        timer_n  = '0;
                        state_n  = ST_PULSE;
                        shadow_n = interval_reg;
                    end
                end
                default: state_n = ST_DISABLED;
            endcase
        end
        beat_n = beat_count;
        if ((paced_n || sensed_n) && beat_count != 16'hFFFF) beat_n = beat_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_DISABLED;
            timer        <= '0;
            interval_reg <= CNT_W'(DEFAULT_INTERVAL);
            shadow       <= CNT_W'(DEFAULT_INTERVAL);
            activate     <= 1'b0;
            paced        <= 1'b0;
            sensed_evt   <= 1'b0;
            beat_count   <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            shadow     <= shadow_n;
            activate   <= act_n;
            paced      <= paced_n;
            sensed_evt <= sensed_n;
            beat_count <= beat_n;
            if (interval_wr) interval_reg <= (interval_data < MIN_INT) ? MIN_INT : interval_data;
        end
    end

endmodule

// File: tb/tb_gastric_pacer.sv
// Directed bench for gastric_pacer (interval 20, refractory 5, pulse 2).
// Hysteresis expectations follow GASTRIC_PACER_HYST_EN when defined.
module tb_gastric_pacer;
    import gastric_pkg::*;

    logic         clk = 1'b0;
    logic         reset, enable, interval_wr, sense;
    logic [15:0]  interval_data;
    logic         activate, paced, sensed_evt;
    logic [15:0]  beat_count;
    pacer_state_t pacer_state;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit pace_at  [0:255];
    bit sevt_at  [0:255];
    bit sense_at [0:255];
    int          wr_at;
    logic [15:0] wr_val;

    gastric_pacer #(
        .CNT_W            (16),
        .DEFAULT_INTERVAL (20),
        .REFRACTORY       (5),
        .PULSE_CYCLES     (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .interval_wr   (interval_wr),
        .interval_data (interval_data),
        .sense         (sense),
        .activate      (activate),
        .paced         (paced),
        .sensed_evt    (sensed_evt),
        .beat_count    (beat_count),
        .pacer_state   (pacer_state)
    );

    always #5 clk = ~clk;

    // One cycle: outputs are read and inputs changed at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) begin
            pace_at[i]  = 1'b0;
            sevt_at[i]  = 1'b0;
            sense_at[i] = 1'b0;
        end
        wr_at  = -1;
        wr_val = '0;
    endtask

    task automatic sense_rise(input int c);
        for (int i = 0; i < 3; i++) sense_at[c+i] = 1'b1;
    endtask

    // Reset through cycle 2, enable sampled high from cycle 10.
    task automatic start_scn();
        reset = 1'b1; enable = 1'b0; sense = 1'b0;
        interval_wr = 1'b0; interval_data = '0;
        cyc = 0;
        step();
        step();
        chk("reset_activate", 32'(activate), 32'd0);
        chk("reset_paced", 32'(paced), 32'd0);
        chk("reset_sensed", 32'(sensed_evt), 32'd0);
        chk("reset_beat", 32'(beat_count), 32'd0);
        chk("reset_state", 32'(pacer_state), 32'(ST_DISABLED));
        reset = 1'b0;
        while (cyc < 10) step();
        enable = 1'b1;
    endtask

    task automatic run_to(input int last);
        while (cyc < last) begin
            step();
            chk("activate", 32'(activate), 32'(pace_at[cyc] || pace_at[cyc-1]));
            chk("paced", 32'(paced), 32'(pace_at[cyc]));
            chk("sensed_evt", 32'(sensed_evt), 32'(sevt_at[cyc]));
            sense         = sense_at[cyc];
            interval_wr   = (cyc == wr_at);
            interval_data = wr_val;
        end
    endtask

    initial begin
        // Free-run
        clear_sched();
        pace_at[31] = 1; pace_at[51] = 1; pace_at[71] = 1;
        start_scn();
        run_to(80);
        chk("freerun_beat", 32'(beat_count), 32'd3);

        // Inhibit by a sensed beat at cycle 40
        clear_sched();
        sense_rise(40); sevt_at[41] = 1; pace_at[31] = 1;
`ifdef GASTRIC_PACER_HYST_EN
        pace_at[111] = 1;
        start_scn();
        run_to(115);
        chk("hyst_beat", 32'(beat_count), 32'd3);
`else
        pace_at[61] = 1; pace_at[81] = 1;
        start_scn();
        run_to(85);
        chk("inhibit_beat", 32'(beat_count), 32'd4);
`endif

        // Sense inside refractory is ignored
        clear_sched();
        sense_rise(34); pace_at[31] = 1; pace_at[51] = 1;
        start_scn();
        run_to(55);
        chk("refract_beat", 32'(beat_count), 32'd2);

        // Sense on the expiry cycle wins
        clear_sched();
        sense_rise(50); sevt_at[51] = 1; pace_at[31] = 1;
`ifdef GASTRIC_PACER_HYST_EN
        start_scn();
        run_to(75);
        chk("tie_beat", 32'(beat_count), 32'd2);
`else
        pace_at[71] = 1;
        start_scn();
        run_to(75);
        chk("tie_beat", 32'(beat_count), 32'd3);
`endif

        // Interval write of 3 clamps to 7 and takes effect after the next pace
        clear_sched();
        wr_at = 40; wr_val = 16'd3;
        pace_at[31] = 1; pace_at[51] = 1; pace_at[58] = 1; pace_at[65] = 1; pace_at[72] = 1;
        start_scn();
        run_to(75);
        chk("clamp_beat", 32'(beat_count), 32'd5);

        // Enable dropped on the first activate cycle
        clear_sched();
        pace_at[31] = 1;
        start_scn();
        run_to(31);
        enable = 1'b0;
        step();
        chk("abort_en_activate", 32'(activate), 32'd0);
        chk("abort_en_paced", 32'(paced), 32'd0);
        chk("abort_en_state", 32'(pacer_state), 32'(ST_DISABLED));
        chk("abort_en_beat", 32'(beat_count), 32'd1);
        step(); step(); step();
        chk("disabled_activate", 32'(activate), 32'd0);
        chk("disabled_beat", 32'(beat_count), 32'd1);

        // Reset on the first activate cycle
        clear_sched();
        pace_at[31] = 1;
        start_scn();
        run_to(31);
        reset = 1'b1;
        step();
        chk("abort_rst_activate", 32'(activate), 32'd0);
        chk("abort_rst_paced", 32'(paced), 32'd0);
        chk("abort_rst_beat", 32'(beat_count), 32'd0);
        chk("abort_rst_state", 32'(pacer_state), 32'(ST_DISABLED));
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gastric_pacer.md
# gastric_pacer

Demand pacemaker directly upstream of the ICC ring chain: generates the `activate` pulse that launches a slow wave into ring 0. An intrinsic activation on `sense` (ring-0 ICC output or an electrode comparator) inside the escape window inhibits pacing. A missing activation causes a pulse at the programmed escape interval. Also reports per-beat events and a beat count to the telemetry logic.

## Interface
- `CNT_W`, 16: width of the timer and interval registers.
- `DEFAULT_INTERVAL`, 400: escape interval in cycles after reset.
- `REFRACTORY`, 40: cycles after any event during which `sense` is ignored.
- `PULSE_CYCLES`, 2: `activate` high time in cycles.
- `HYST_CYCLES`, 50: extra escape cycles after a sensed beat; used only with the macro.

Ports:
- `clk`, in, 1: the block's single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: pacer on/off.
- `interval_wr`, in, 1: load `interval_data`.
- `interval_data`, in, `CNT_W`: new escape interval.
- `sense`, in, 1: intrinsic activation, level; already synchronous to `clk`.
- `activate`, out, 1: stimulus to ring 0.
- `paced`, out, 1: 1-cycle strobe on a paced beat.
- `sensed_evt`, out, 1: 1-cycle strobe on an accepted intrinsic beat.
- `beat_count`, out, 16: paced plus sensed beats; saturates at 0xFFFF.

## Operation
- States: DISABLED, PULSE, REFRACT, ESCAPE. One timer counts from the last event and is cleared to 0 on each event.
- Event sources: enable start, pace, or accepted sense.
- Reset:
  - State goes to DISABLED and the timer to 0.
  - Interval register and shadow load `DEFAULT_INTERVAL`.
  - `beat_count`, `sense_q` and all outputs go to 0.
- DISABLED → REFRACT when `enable`=1, with the timer at 0.
- Any state → DISABLED on the cycle after `enable` is sampled 0:
  - `activate` drops, including in the middle of a pulse.
  - `beat_count` is held.
- REFRACT:
  - `sense` is ignored.
  - Moves to ESCAPE once the timer reaches `REFRACTORY`-1.
- ESCAPE, with an accepted sense (`sense`=1 and `sense_q`=0 in the same cycle):
  - Next cycle: `sensed_evt`=1, timer=0, state REFRACT.
  - No pulse is issued.
- ESCAPE, with the timer at shadow_interval-1 and no accepted sense:
  - Next cycle: `activate`=1, `paced`=1, timer=0, state PULSE.
- Simultaneous accepted sense and escape expiry: the sense wins and the pace is inhibited.
- PULSE:
  - `activate` stays high while the timer is below `PULSE_CYCLES`, then the state moves to REFRACT.
  - `sense` is ignored.
- Interval writes:
  - `interval_wr` updates the interval register.
  - Values below MIN_INTERVAL = `REFRACTORY`+`PULSE_CYCLES` are clamped to MIN_INTERVAL.
  - The shadow interval copies the register on every event, so a write never alters the current cycle.
- `beat_count` increments on `paced` or `sensed_evt` and stops at 0xFFFF.
- The timer saturates at all-ones.

## Timing
- Outputs are registered, with no combinational path from input to output.
- `enable` sampled high at cycle E: the first `activate` appears at E+1+interval if nothing is sensed.
- Paced period is exactly interval cycles, rising edge to rising edge.
- `sense` rising at cycle c (timer ≥ `REFRACTORY`) produces `sensed_evt` at c+1. The next pace is then at c+1+interval.
- `reset` mid-pulse: `activate` is 0 on the next cycle.

## Configuration
- `GASTRIC_PACER_HYST_EN` defined: a sensed event latches shadow = interval+`HYST_CYCLES`, saturating at `CNT_W`. A paced event latches the plain interval.
- Undefined: every event latches the plain interval and `HYST_CYCLES` is unused.

## Structure
- Package `gastric_pkg` holds:
  - the `pacer_state_t` enum;
  - default constants `DEFAULT_INTERVAL`, `REFRACTORY`, `PULSE_CYCLES`;
  - the MIN_INTERVAL function.
- Sub-module `rise_detect` (`sense` → 1-cycle rise strobe plus `sense_q`) is natural. Everything else stays in one FSM+timer module.

## Test plan
Bench parameters: interval 20, `REFRACTORY` 5, `PULSE_CYCLES` 2.
- Free-run: `enable` high at cycle 10, `sense` held 0.
  - `activate` high at cycles 31–32, 51–52, 71–72.
  - `paced` strobes at 31, 51, 71.
  - `beat_count` reads 3 after cycle 71.
- Inhibit: pace at cycle 31, `sense` rises at cycle 40.
  - `sensed_evt` at 41.
  - Next `activate` at 61, not 51.
- Refractory: `sense` rises 3 cycles after a pace.
  - No `sensed_evt`.
  - Next pace 20 cycles after the previous one.
- Tie: `sense` rises on the same cycle the timer reaches 19.
  - `sensed_evt`=1, `activate` stays 0.
- Clamp and latching: write `interval_data`=3 during ESCAPE.
  - The current period stays 20.
  - Subsequent periods are 7.
- Abort: `enable` or `reset` asserted on the first `activate` cycle.
  - `activate` is 0 the next cycle.
  - Under reset, `beat_count` is 0.
  - With the macro defined, a sensed beat followed by no sense gives a next pace 70 cycles later.
